// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types, constants and byte-lane merge helper for the memory bus initiator
package mem_bus_pkg;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_e;
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] sampled,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [STRB_W-1:0] wstrb);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < STRB_W; i++) m[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : sampled[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/mem_master.sv
// mem_master: byte-strobed request port to single-cycle word bus initiator with read-modify-write
// Ports: clk/rst (async active-low); req_* core request; resp_* core response;
//        mem_we/mem_addr/mem_data word bus (mem_data driven only while mem_we=1).
// Optional: define MEM_MASTER_ADDR_CHECK_EN to reject word addresses >= ADDR_WORDS with resp_err.
module mem_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WORDS = 1024,
  parameter int DATA_W = mem_bus_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);
  state_e state_q, state_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic err_q, err_d;
  logic [31:0] req_waddr;
  logic addr_bad;
  logic unused_bits;
  assign req_waddr = {2'b00, req_addr[31:2]};
`ifdef MEM_MASTER_ADDR_CHECK_EN
  assign addr_bad = req_waddr >= 32'(ADDR_WORDS);
  assign unused_bits = ^req_addr[1:0];
`else
  assign addr_bad = 1'b0;
  assign unused_bits = ^req_addr[1:0] ^ (ADDR_WORDS > 0);
`endif
  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d = err_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: if (req_valid) begin
        wdata_d = req_wdata;
        wstrb_d = req_wstrb;
        rdata_d = '0;
        err_d = 1'b0;
        if (addr_bad) begin
          state_d = RESP;
          err_d = 1'b1;
          rdata_d = ERR_RDATA;
        end else if (req_we && req_wstrb == '0) begin
          state_d = RESP;
        end else begin
          mem_addr_d = req_waddr;
          state_d = !req_we ? RD : &req_wstrb ? WR : RMW_RD;
        end
      end
      RD: begin
        rdata_d = mem_data;
        state_d = RESP;
      end
      RMW_RD: begin
        wdata_d = merge_lanes(mem_data, wdata_q, wstrb_q);
        state_d = WR;
      end
      WR: state_d = RESP;
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      mem_addr_q <= mem_addr_d;
    end
  end
  // Write enable and data drive share one decode of the state register, so the
  // bus is released on the same edge (or async reset) that drops mem_we.
  assign mem_we = state_q == WR;
  assign mem_data = mem_we ? wdata_q : 'z;
  assign mem_addr = mem_addr_q;
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
endmodule
